// File: rtl/gates_checker_pkg.sv
// gates_checker_pkg: shared encodings, widths and vector table for the gate checker
package gates_checker_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  localparam int IDX_W = 2;
  localparam int ERR_W = 3;
  localparam int CNT_W = 4;
  localparam int NUM_VEC = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  // entry i sits at bits [2i+1:2i] as {a,b}
  localparam logic [2*NUM_VEC-1:0] VEC_TABLE = {2'b11, 2'b01, 2'b10, 2'b00};
  function automatic logic [1:0] vec_at(input logic [IDX_W-1:0] i);
    return VEC_TABLE[2*i +: 2];
  endfunction
endpackage

// File: rtl/gates_expected.sv
// gates_expected: reference OR/AND/NOT responses for a stimulus pair
module gates_expected (
  input  logic a,
  input  logic b,
  output logic exp_or,
  output logic exp_and,
  output logic exp_not
);
  assign exp_or = a | b;
  assign exp_and = a & b;
  assign exp_not = ~a;
endmodule

// File: rtl/gates_checker.sv
// gates_checker: drives four fixed vectors into a gate DUT and scores its responses
module gates_checker
  import gates_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             outA,
  output logic             outB,
  input  logic             inOr,
  input  logic             inAnd,
  input  logic             inNot,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] errCount,
  output logic [NUM_VEC-1:0] failMask
);
  if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range");
  end
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);
  state_t state, next;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic exp_or, exp_and, exp_not, mismatch;
  gates_expected u_expected (
    .a(outA),
    .b(outB),
    .exp_or(exp_or),
    .exp_and(exp_and),
    .exp_not(exp_not)
  );
  assign mismatch = {inOr, inAnd, inNot} != {exp_or, exp_and, exp_not};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    busy = state == DRIVE || state == SETTLE || state == CHECK;
    case (state)
      IDLE:    next = start ? DRIVE : IDLE;
      DRIVE:   next = SETTLE;
      SETTLE:  next = cnt == SETTLE_LAST ? CHECK : SETTLE;
      CHECK:   next = idx == IDX_LAST ? DONE : DRIVE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  // results are loaded on the DONE edge, so done and the final pass appear together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outA <= 1'b0;
      outB <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      errCount <= '0;
      failMask <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          idx <= '0;
          errCount <= '0;
          failMask <= '0;
          pass <= 1'b0;
        end
        DRIVE: begin
          {outA, outB} <= vec_at(idx);
          cnt <= '0;
        end
        SETTLE: cnt <= cnt + 1'b1;
        CHECK: begin
          if (mismatch) begin
            failMask[idx] <= 1'b1;
            errCount <= errCount + 1'b1;
          end
          if (idx != IDX_LAST) idx <= idx + 1'b1;
        end
        DONE: pass <= errCount == '0;
        default: ;
      endcase
    end
  end
endmodule
